// File: rtl/cache_lookup_dm_if.sv
// rtl/cache_lookup_dm_if.sv - CPU request/response and line-fill bundle for cache_lookup_dm
interface cache_lookup_dm_if #(
  parameter int TAG_W      = 4,
  parameter int INDEX_W    = 2,
  parameter int LINE_WORDS = 32,
  parameter int DATA_W     = 8
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int ADDR_W = TAG_W + INDEX_W + OFF_W;
  localparam int LINE_W = TAG_W + INDEX_W;

  // CPU load port
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_hit;

  // backing memory line fetch
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [LINE_W-1:0] mem_req_line;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  // cache engine side
  modport slave (
    input  req_valid, req_addr, flush, resp_ready, mem_req_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_line
  );

  // CPU + memory side (environment)
  modport master (
    output req_valid, req_addr, flush, resp_ready, mem_req_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_line
  );
endinterface

// File: rtl/cache_lookup_dm.sv
// rtl/cache_lookup_dm.sv - direct-mapped cache lookup engine; CACHE_STATS_EN adds saturating hit/miss counters
module cache_lookup_dm #(
  parameter int TAG_W      = 4,
  parameter int INDEX_W    = 2,
  parameter int LINE_WORDS = 32,
  parameter int DATA_W     = 8,
  parameter int STATS_W    = 16
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
`ifdef CACHE_STATS_EN
  output logic [STATS_W-1:0]  hit_cnt_o,
  output logic [STATS_W-1:0]  miss_cnt_o,
`endif
  cache_lookup_dm_if.slave    bus
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int ADDR_W = TAG_W + INDEX_W + OFF_W;
  localparam int LINES  = 1 << INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_FILL   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_arr_q  [LINES];
  logic [DATA_W-1:0]     data_arr_q [LINES][LINE_WORDS];
  logic [OFF_W-1:0]      cnt_q;
  logic                  mem_acked_q;
  logic                  hit_q;

  logic [TAG_W-1:0]      tag_w;
  logic [INDEX_W-1:0]    idx_w;
  logic [OFF_W-1:0]      off_w;
  logic                  lookup_hit;
  logic                  beat_fire;
  logic                  last_beat;

  // Latched request fields; the request address is held for the whole transaction.
  assign tag_w = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_w = addr_q[OFF_W +: INDEX_W];
  assign off_w = addr_q[OFF_W-1:0];

  assign lookup_hit = valid_q[idx_w] && (tag_arr_q[idx_w] == tag_w);
  // Beats only count once the fetch request has been handshaken.
  assign beat_fire  = (state_q == S_FILL) && mem_acked_q && bus.mem_rvalid;
  assign last_beat  = beat_fire && (cnt_q == OFF_W'(LINE_WORDS - 1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d           = state_q;
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_data     = '0;
    bus.resp_hit      = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_line  = '0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = !bus.flush;
        if (!bus.flush && bus.req_valid) begin
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d = lookup_hit ? S_RESP : S_FILL;
      end
      S_FILL: begin
        bus.mem_req_valid = !mem_acked_q;
        if (!mem_acked_q) begin
          bus.mem_req_line = {tag_w, idx_w};
        end
        if (last_beat) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_data  = data_arr_q[idx_w][off_w];
        bus.resp_hit   = hit_q;
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers: address latch, valid bits, fill progress and hit flag.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      addr_q      <= '0;
      valid_q     <= '0;
      cnt_q       <= '0;
      mem_acked_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.flush) begin
            valid_q <= '0;
          end else if (bus.req_valid) begin
            addr_q <= bus.req_addr;
          end
        end
        S_LOOKUP: begin
          hit_q <= lookup_hit;
          if (!lookup_hit) begin
            // The line is being replaced, so it must not look valid while partially written.
            valid_q[idx_w] <= 1'b0;
            cnt_q          <= '0;
            mem_acked_q    <= 1'b0;
          end
        end
        S_FILL: begin
          if (!mem_acked_q && bus.mem_req_ready) begin
            mem_acked_q <= 1'b1;
          end
          if (beat_fire) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (last_beat) begin
            valid_q[idx_w] <= 1'b1;
            cnt_q          <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tag and data arrays: written only by fill beats, never reset.
  always_ff @(posedge clk_i) begin
    if (beat_fire) begin
      data_arr_q[idx_w][cnt_q] <= bus.mem_rdata;
    end
    if (last_beat) begin
      tag_arr_q[idx_w] <= tag_w;
    end
  end

`ifdef CACHE_STATS_EN
  logic [STATS_W-1:0] hit_cnt_q;
  logic [STATS_W-1:0] miss_cnt_q;

  // Saturating hit/miss counters, bumped once per lookup; flush leaves them alone.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (lookup_hit) begin
        if (hit_cnt_q != {STATS_W{1'b1}}) begin
          hit_cnt_q <= hit_cnt_q + 1'b1;
        end
      end else begin
        if (miss_cnt_q != {STATS_W{1'b1}}) begin
          miss_cnt_q <= miss_cnt_q + 1'b1;
        end
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
